// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter
//
// Two-port arbiter in front of a HyperRAM controller. One requester at a time
// is granted. Its address, write data, write enable and byte mask are latched
// into the ram_* registers, and a single-cycle ram_transaction_begin pulse is
// issued. The arbiter then waits for the controller to run the transaction
// and returns a one-cycle ack to the granted port. On a read, the ack also
// carries the returned data.
//
// Handshakes:
//   Requester side
//     - pN_req is held high until acknowledged.
//     - pN_addr, pN_wdata, pN_we and pN_wmask are stable while pN_req is high.
//     - pN_ack is a one-cycle completion pulse.
//     - pN_rdata is loaded on the edge where pN_ack rises, and only for reads.
//     - A request that is dropped after it has been granted still completes
//       and is still acked.
//   Controller side
//     - ram_transaction_end high means the controller is idle.
//     - The controller starts on ram_transaction_begin and signals it has
//       started by pulling ram_transaction_end low.
//     - When ram_transaction_end returns high, ram_data_in must be valid.
//
// Configuration macro: HYPERRAM_ARB_RR_EN
//   - Defined: simultaneous requests are resolved round-robin against a
//     last-grant register.
//   - Undefined: port 0 always wins a simultaneous request.
//
// Parameters
//   START_TIMEOUT   number of cycles to wait for ram_transaction_end to fall
//                   before the begin is re-issued
//   GUARD_CYCLES    number of idle cycles between a response and the next
//                   arbitration
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_req/addr/wdata/we/wmask   requester N command (N = 0, 1)
//   pN_ack, pN_rdata             requester N completion pulse and read data
//   ram_address/data_out/
//   write_enable/write_mask      latched command to the controller
//   ram_transaction_begin        one-cycle start pulse to the controller
//   ram_data_in                  read data from the controller
//   ram_transaction_end          controller idle flag
//   busy                         high in any state except IDLE
//   owner                        index of the granted port
//   dbg_state                    current FSM state encoding
module hyperram_arbiter #(
    parameter int START_TIMEOUT = 15,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_req,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [3:0]  p0_wmask,
    output logic        p0_ack,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [3:0]  p1_wmask,
    output logic        p1_ack,
    output logic [31:0] p1_rdata,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_out,
    output logic        ram_write_enable,
    output logic [3:0]  ram_write_mask,
    output logic        ram_transaction_begin,
    input  logic [31:0] ram_data_in,
    input  logic        ram_transaction_end,
    output logic        busy,
    output logic        owner,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SETUP      = 3'd1,
        ISSUE      = 3'd2,
        WAIT_START = 3'd3,
        WAIT_END   = 3'd4,
        RESP       = 3'd5,
        GUARD      = 3'd6
    } state_t;

    // One counter serves both the start timeout and the guard interval.
    // The two are never active at the same time.
    localparam int CNT_MAX = (START_TIMEOUT > GUARD_CYCLES) ? START_TIMEOUT : GUARD_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] ST_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] GD_LAST = CW'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_clr;
    logic          w_cnt_inc;
    logic          w_grant;
    logic          w_win;
    logic          w_done;

    logic          r_owner;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic [3:0]    r_wmask;
    logic          r_ack0;
    logic          r_ack1;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;

`ifdef HYPERRAM_ARB_RR_EN
    logic          r_last;

    // On a tie, grant the port that did not win last time.
    // Otherwise, grant whichever port is requesting.
    always_comb begin
        w_win = 1'b0;
        if (p0_req && p1_req) begin
            w_win = ~r_last;
        end else begin
            w_win = ~p0_req;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it is requesting.
    always_comb begin
        w_win = ~p0_req;
    end
`endif

    // Completion is seen on the edge that leaves WAIT_END.
    // The ack rises and the read data are captured on that same edge.
    assign w_done = (r_state == WAIT_END) && ram_transaction_end;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and counter controls
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if ((p0_req || p1_req) && ram_transaction_end) begin
                    w_grant      = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ISSUE;
            end
            ISSUE: begin
                w_next_state = WAIT_START;
            end
            WAIT_START: begin
                if (!ram_transaction_end) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = WAIT_END;
                end else if (r_cnt == ST_LAST) begin
                    // The controller never started: pulse begin again.
                    w_cnt_clr    = 1'b1;
                    w_next_state = ISSUE;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            WAIT_END: begin
                if (ram_transaction_end) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = (GUARD_CYCLES == 0) ? IDLE : GUARD;
            end
            GUARD: begin
                if (r_cnt == GD_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_cnt_inc    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shared timeout/guard counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Command latch, acks and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_wmask  <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_grant) begin
                r_owner <= w_win;
                r_addr  <= w_win ? p1_addr  : p0_addr;
                r_wdata <= w_win ? p1_wdata : p0_wdata;
                r_we    <= w_win ? p1_we    : p0_we;
                r_wmask <= w_win ? p1_wmask : p0_wmask;
            end
            if (w_done) begin
                if (r_owner) begin
                    r_ack1 <= 1'b1;
                    if (!r_we) begin
                        r_rdata1 <= ram_data_in;
                    end
                end else begin
                    r_ack0 <= 1'b1;
                    if (!r_we) begin
                        r_rdata0 <= ram_data_in;
                    end
                end
            end
        end
    end

`ifdef HYPERRAM_ARB_RR_EN
    // Last-grant register; resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    assign p0_ack                = r_ack0;
    assign p1_ack                = r_ack1;
    assign p0_rdata              = r_rdata0;
    assign p1_rdata              = r_rdata1;
    assign ram_address           = r_addr;
    assign ram_data_out          = r_wdata;
    assign ram_write_enable      = r_we;
    assign ram_write_mask        = r_wmask;
    assign ram_transaction_begin = (r_state == ISSUE);
    assign busy                  = (r_state != IDLE);
    assign owner                 = r_owner;
    assign dbg_state             = r_state;

endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter
//
// Directed bench for hyperram_arbiter.
//
// The bench contains a small HyperRAM controller model:
//   - It answers each begin by pulling ram_transaction_end low for 2 + ctl_extra
//     cycles, then returns it high with data from a backing memory.
//   - It can be told to ignore a number of begins.
//
// Scoreboard:
//   - Expected read data (per port) and expected grant order are pushed when a
//     request is raised.
//   - They are popped and compared when the matching ack is seen.
//
// Expectations for simultaneous requests follow HYPERRAM_ARB_RR_EN.
module tb_hyperram_arbiter;

    localparam int START_TIMEOUT = 15;
    localparam int GUARD_CYCLES  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] ram_address, ram_data_out, ram_data_in;
    logic        ram_write_enable, ram_transaction_begin, ram_transaction_end;
    logic [3:0]  ram_write_mask;
    logic        busy, owner;
    logic [2:0]  dbg_state;

    hyperram_arbiter #(
        .START_TIMEOUT(START_TIMEOUT),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .p0_req               (p0_req),
        .p0_addr              (p0_addr),
        .p0_wdata             (p0_wdata),
        .p0_we                (p0_we),
        .p0_wmask             (p0_wmask),
        .p0_ack               (p0_ack),
        .p0_rdata             (p0_rdata),
        .p1_req               (p1_req),
        .p1_addr              (p1_addr),
        .p1_wdata             (p1_wdata),
        .p1_we                (p1_we),
        .p1_wmask             (p1_wmask),
        .p1_ack               (p1_ack),
        .p1_rdata             (p1_rdata),
        .ram_address          (ram_address),
        .ram_data_out         (ram_data_out),
        .ram_write_enable     (ram_write_enable),
        .ram_write_mask       (ram_write_mask),
        .ram_transaction_begin(ram_transaction_begin),
        .ram_data_in          (ram_data_in),
        .ram_transaction_end  (ram_transaction_end),
        .busy                 (busy),
        .owner                (owner),
        .dbg_state            (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    int begin_cnt = 0;
    int begin_cyc[$];
    int ign_budget = 0;
    int ign_used   = 0;
    int ctl_extra  = 0;

    logic [31:0] mem[logic [31:0]];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [0:0]  exp_own_q[$];
    logic [31:0] exp_rd[2];
    int          ack_cnt[2];

    logic        stab_on = 1'b0;
    logic [31:0] stab_a, stab_d;
    int          stab_n = 0;
    int          stab_err = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_A5A5);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hA5A5_A5A5);
    endfunction

    // ---------------- controller model ----------------
    initial begin : ctl_model
        logic [31:0] a, d;
        logic        w;
        logic [3:0]  m;
        ram_transaction_end = 1'b1;
        ram_data_in = '0;
        forever begin
            @(negedge clk);
            if (rst_n && ram_transaction_begin) begin
                begin_cnt++;
                begin_cyc.push_back(cyc);
                if (ign_used < ign_budget) begin
                    ign_used++;
                end else begin
                    a = ram_address;
                    d = ram_data_out;
                    w = ram_write_enable;
                    m = ram_write_mask;
                    ram_transaction_end = 1'b0;
                    repeat (2 + ctl_extra) @(negedge clk);
                    if (w) mem[a] = merge(mdl_rd(a), d, m);
                    else   ram_data_in = mdl_rd(a);
                    ram_transaction_end = 1'b1;
                end
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One negedge step; the scoreboard pops on every ack seen.
    task automatic tick();
        logic pp;
        @(negedge clk);
        if (rst_n) begin
            if (p0_ack || p1_ack) begin
                pp = p1_ack;
                chk("ack_onehot", {31'd0, p0_ack & p1_ack}, 32'd0);
                chk("ack_owner", {31'd0, owner}, {31'd0, pp});
                ack_cnt[pp]++;
                chk("ack_expected", {31'd0, exp_own_q.size() != 0}, 32'd1);
                if (exp_own_q.size() != 0)
                    chk("grant_order", {31'd0, pp}, {31'd0, exp_own_q.pop_front()});
                if (pp) begin
                    if (exp_q1.size() != 0) chk("p1_rdata", p1_rdata, exp_q1.pop_front());
                end else begin
                    if (exp_q0.size() != 0) chk("p0_rdata", p0_rdata, exp_q0.pop_front());
                end
            end
            if (stab_on && (dbg_state inside {[3'd1:3'd5]})) begin
                stab_n++;
                if ({ram_address, ram_data_out, ram_write_enable, ram_write_mask} !==
                    {stab_a, stab_d, 1'b1, 4'hF}) stab_err++;
            end
        end
    endtask

    task automatic settle();
        repeat (GUARD_CYCLES + 2) tick();
    endtask

    // ---------------- driver tasks ----------------
    task automatic raise(input logic p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        logic [31:0] e;
        if (we) begin
            e = exp_rd[p];
            ref_mem[a] = merge(ref_rd(a), d, m);
        end else begin
            e = ref_rd(a);
            exp_rd[p] = e;
        end
        if (p) begin
            exp_q1.push_back(e);
            p1_addr = a; p1_wdata = d; p1_we = we; p1_wmask = m; p1_req = 1'b1;
        end else begin
            exp_q0.push_back(e);
            p0_addr = a; p0_wdata = d; p0_we = we; p0_wmask = m; p0_req = 1'b1;
        end
    endtask

    task automatic run_txn(input logic p, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           input int drop_after, output int lat);
        lat = -1;
        raise(p, we, a, d, m);
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (drop_after > 0 && c == drop_after) begin
                if (p) p1_req = 1'b0; else p0_req = 1'b0;
            end
            if ((p ? p1_ack : p0_ack) === 1'b1) begin
                lat = c;
                break;
            end
        end
        if (p) p1_req = 1'b0; else p0_req = 1'b0;
        chk("ack_seen", {31'd0, lat > 0}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int lat, b0, k0, a0, gap, done0, done1, acks0, sn0, se0;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        p0_wmask = 0; p1_wmask = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;

        // reset values
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        chk("rst_begin", {31'd0, ram_transaction_begin}, 32'd0);
        chk("rst_addr", ram_address, 32'd0);
        chk("rst_dout", ram_data_out, 32'd0);
        chk("rst_we_mask", {27'd0, ram_write_enable, ram_write_mask}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle();

        // single read, p0 @0x100
        b0 = begin_cnt;
        exp_own_q.push_back(1'b0);
        run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, lat);
        chk("rd_begins", begin_cnt - b0, 32'd1);
        chk("rd_data", p0_rdata, 32'hDEAD_BEEF);
        chk("rd_latency", lat, 32'd5);
        // guard interval then idle
        tick(); chk("guard1_busy", {31'd0, busy}, 32'd1);
        tick(); chk("guard2_busy", {31'd0, busy}, 32'd1);
        tick(); chk("guard_idle", {31'd0, busy}, 32'd0);

        // single write, p1 @0x300, command stable from SETUP to ack
        stab_a = 32'h300; stab_d = 32'h1234_5678;
        sn0 = stab_n; se0 = stab_err;
        stab_on = 1'b1;
        exp_own_q.push_back(1'b1);
        run_txn(1'b1, 1'b1, 32'h300, 32'h1234_5678, 4'hF, 0, lat);
        stab_on = 1'b0;
        chk("wr_stable_err", stab_err - se0, 32'd0);
        chk("wr_stable_samples", stab_n - sn0, 32'd5);
        chk("wr_rdata_kept", p1_rdata, 32'd0);
        settle();

        // contention: both ports request continuously, two reads each
`ifdef HYPERRAM_ARB_RR_EN
        exp_own_q.push_back(1'b0); exp_own_q.push_back(1'b1);
        exp_own_q.push_back(1'b0); exp_own_q.push_back(1'b1);
`else
        exp_own_q.push_back(1'b0); exp_own_q.push_back(1'b0);
        exp_own_q.push_back(1'b1); exp_own_q.push_back(1'b1);
`endif
        done0 = 0; done1 = 0;
        raise(1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
        raise(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        for (int c = 0; c < 400; c++) begin
            if (done0 == 2 && done1 == 2) break;
            tick();
            if (p0_ack) begin
                done0++;
                if (done0 < 2) raise(1'b0, 1'b0, 32'h404, 32'h0, 4'h0);
                else p0_req = 1'b0;
            end
            if (p1_ack) begin
                done1++;
                if (done1 < 2) raise(1'b1, 1'b0, 32'h504, 32'h0, 4'h0);
                else p1_req = 1'b0;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        chk("cont_done0", done0, 32'd2);
        chk("cont_done1", done1, 32'd2);
        settle();

        // start timeout: first begin ignored, re-issued after START_TIMEOUT
        ign_budget = ign_budget + 1;
        b0 = begin_cnt; k0 = begin_cyc.size(); a0 = ack_cnt[0];
        exp_own_q.push_back(1'b0);
        run_txn(1'b0, 1'b0, 32'h180, 32'h0, 4'h0, 0, lat);
        gap = (begin_cyc.size() >= k0 + 2) ? (begin_cyc[k0+1] - begin_cyc[k0]) : -1;
        chk("to_begins", begin_cnt - b0, 32'd2);
        chk("to_gap", gap, START_TIMEOUT + 1);
        chk("to_acks", ack_cnt[0] - a0, 32'd1);
        chk("to_latency", lat, 5 + START_TIMEOUT + 1);
        settle();

        // requester drops req after grant: still acked
        exp_own_q.push_back(1'b1);
        run_txn(1'b1, 1'b0, 32'h1C0, 32'h0, 4'h0, 2, lat);
        chk("drop_latency", lat, 32'd5);
        settle();

        // slow controller, read back the earlier write
        ctl_extra = 3;
        exp_own_q.push_back(1'b0);
        run_txn(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 0, lat);
        ctl_extra = 0;
        chk("slow_latency", lat, 32'd8);
        chk("readback", p0_rdata, 32'h1234_5678);
        settle();

        // reset while in WAIT_END: abort, no ack
        ctl_extra = 6;
        p0_addr = 32'h200; p0_we = 1'b0; p0_wmask = 4'h0; p0_req = 1'b1;
        k0 = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (dbg_state == 3'd4) begin
                k0 = 1;
                break;
            end
        end
        chk("reach_wait_end", k0, 32'd1);
        p0_req = 1'b0;
        acks0 = ack_cnt[0] + ack_cnt[1];
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_acks", {30'd0, p0_ack, p1_ack}, 32'd0);
        chk("mid_rst_ram", ram_address | ram_data_out, 32'd0);
        chk("mid_rst_ctl", {26'd0, ram_transaction_begin, ram_write_enable, ram_write_mask}, 32'd0);
        chk("mid_rst_rdata", p0_rdata | p1_rdata, 32'd0);
        chk("mid_rst_owner", {31'd0, owner}, 32'd0);
        repeat (12) @(negedge clk);
        ctl_extra = 0;
        rst_n = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (10) tick();
        chk("no_ack_after_rst", ack_cnt[0] + ack_cnt[1], acks0);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        // recovery after reset
        exp_own_q.push_back(1'b1);
        run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, lat);
        chk("post_rst_latency", lat, 32'd5);
        chk("post_rst_data", p1_rdata, 32'hDEAD_BEEF);
        settle();
        chk("sb_drained", exp_own_q.size() + exp_q0.size() + exp_q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
